wb_pipe_reg: RTL and testbench

WB_PIPE_REG -- requirements
Module: wb_pipe_reg

---
 rtl/wb_pipe_pkg.sv | 23 ++
 rtl/pipe_entry_reg.sv | 37 +++
 rtl/wb_pipe_reg.sv | 160 ++++++++++++++++
 tb/tb_wb_pipe_reg.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pipe_pkg.sv
// Shared definitions for the writeback pipeline register.
//   pipe_state_e        : occupancy state of the stage (EMPTY / FULL / SKID)
//   WB_PIPE_DEFAULT_W   : default payload lane width
//   state_count()       : number of held entries for a given state
package wb_pipe_pkg;

  localparam int unsigned WB_PIPE_DEFAULT_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  function automatic logic [1:0] state_count(input pipe_state_e s);
    case (s)
      FULL:    return 2'd1;
      SKID:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: CH lanes of W bits held as a single word so the lanes
// always move together.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears the entry)
//   i_load        : capture i_d on the next rising edge
//   i_clear       : zero the entry on the next rising edge (wins over i_load)
//   i_d           : entry to capture
//   o_q           : held entry
module pipe_entry_reg
  import wb_pipe_pkg::*;
#(
  parameter int unsigned W  = WB_PIPE_DEFAULT_W,
  parameter int unsigned CH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [CH-1:0][W-1:0]  i_d,
  output logic [CH-1:0][W-1:0]  o_q
);

  logic [CH-1:0][W-1:0] r_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/wb_pipe_reg.sv
// Writeback pipeline register: a one-deep registered stage between execute
// and writeback, carrying CH payload lanes (lane 0 = writeback data,
// lane 1 = instruction) as one atomic entry.
//
// Handshake: an entry moves across a port only in a cycle where both valid
// and ready are high. Once out_valid_o is raised it stays high, and
// out_data_o stays unchanged, until out_ready_i accepts the entry (or a
// flush/reset discards it). Entries leave in the order they were accepted.
//
// Configuration macro WB_PIPE_REG_SKID_EN:
//   defined   : a skid register absorbs one extra entry (SKID state); in_ready_o
//               is registered, so there is no combinational path from out_ready_i.
//   undefined : single entry only; in_ready_o = out_ready_i | ~out_valid_o.
//
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   flush_i         : synchronous flush, discards every held entry
//   in_valid_i/in_ready_o/in_data_i    : upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o : downstream handshake and registered payload
//   count_o         : number of held entries (0..2)
//   dbg_state_o     : current FSM state, for observation only
module wb_pipe_reg
  import wb_pipe_pkg::*;
#(
  parameter int unsigned W  = WB_PIPE_DEFAULT_W,
  parameter int unsigned CH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [CH-1:0][W-1:0]  in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CH-1:0][W-1:0]  out_data_o,
  output logic [1:0]            count_o,
  output pipe_state_e           dbg_state_o
);

`ifdef WB_PIPE_REG_SKID_EN
  localparam bit HAS_SKID = 1'b1;
`else
  localparam bit HAS_SKID = 1'b0;
`endif

  pipe_state_e          r_state;
  pipe_state_e          w_state_next;
  logic                 w_accept;
  logic                 w_drain;
  logic                 w_main_load;
  logic                 w_main_clear;
  logic [CH-1:0][W-1:0] w_main_d;
  logic                 w_skid_load;
  logic                 w_skid_clear;
  logic [CH-1:0][W-1:0] w_skid_q;

  assign w_accept    = in_valid_i & in_ready_o;
  assign w_drain     = out_valid_o & out_ready_i;
  assign out_valid_o = (r_state != EMPTY);
  assign count_o     = state_count(r_state);
  assign dbg_state_o = r_state;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. Flush wins over any handshake in the same cycle.
  always_comb begin
    w_state_next = r_state;
    if (flush_i) begin
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_accept) w_state_next = FULL;
        FULL: begin
          // Without a skid register the accept-without-drain case cannot
          // happen, because in_ready_o follows out_ready_i while FULL.
          if (w_accept && !w_drain) w_state_next = HAS_SKID ? SKID : FULL;
          else if (!w_accept && w_drain) w_state_next = EMPTY;
        end
        SKID:    if (w_drain) w_state_next = FULL;
        default: w_state_next = EMPTY;
      endcase
    end
  end

  // Datapath controls for the main and skid entries.
  always_comb begin
    w_main_load  = 1'b0;
    w_main_clear = flush_i;
    w_main_d     = in_data_i;
    w_skid_load  = 1'b0;
    w_skid_clear = flush_i;
    if (!flush_i) begin
      case (r_state)
        EMPTY: w_main_load = w_accept;
        FULL: begin
          if (w_accept && w_drain) w_main_load = 1'b1;
          else if (w_accept)       w_skid_load = 1'b1;
        end
        SKID: begin
          // The older entry leaves; the skid entry becomes the head.
          if (w_drain) begin
            w_main_load  = 1'b1;
            w_main_d     = w_skid_q;
            w_skid_clear = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  pipe_entry_reg #(.W(W), .CH(CH)) u_main (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_d     (w_main_d),
    .o_q     (out_data_o)
  );

`ifdef WB_PIPE_REG_SKID_EN
  logic r_in_ready;

  pipe_entry_reg #(.W(W), .CH(CH)) u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_d     (in_data_i),
    .o_q     (w_skid_q)
  );

  // Ready is decided one cycle ahead: high unless the stage is about to be
  // completely full.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_state_next != SKID);
    end
  end

  assign in_ready_o = r_in_ready;
`else
  logic w_unused_skid;

  assign w_skid_q      = '0;
  assign w_unused_skid = w_skid_load | w_skid_clear;
  assign in_ready_o    = out_ready_i | ~out_valid_o;
`endif

endmodule

// File: tb/tb_wb_pipe_reg.sv
module tb_wb_pipe_reg;
  import wb_pipe_pkg::*;

  localparam int W   = 32;
  localparam int CH  = 2;
  localparam int W4  = 8;
  localparam int CH4 = 4;
`ifdef WB_PIPE_REG_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- main DUT (W=32, CH=2) ----------------
  logic                 flush, in_valid, in_ready, out_valid, out_ready;
  logic [CH-1:0][W-1:0] in_data, out_data;
  logic [1:0]           count;
  pipe_state_e          unused_dbg_state;

  wb_pipe_reg #(.W(W), .CH(CH)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .count_o(count), .dbg_state_o(unused_dbg_state)
  );

  // ---------------- lane-atomicity DUT (W=8, CH=4) ----------------
  logic                   in_valid4, in_ready4, out_valid4, out_ready4;
  logic [CH4-1:0][W4-1:0] in_data4, out_data4;
  logic [1:0]             unused_count4;
  pipe_state_e            unused_dbg_state4;

  wb_pipe_reg #(.W(W4), .CH(CH4)) u_dut4 (
    .clk_i(clk_i), .rst_ni(rst_n), .flush_i(1'b0),
    .in_valid_i(in_valid4), .in_ready_o(in_ready4), .in_data_i(in_data4),
    .out_valid_o(out_valid4), .out_ready_i(out_ready4), .out_data_o(out_data4),
    .count_o(unused_count4), .dbg_state_o(unused_dbg_state4)
  );

  // ---------------- scoreboard / checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the stage is a FIFO of at most CAP entries.
  logic [CH-1:0][W-1:0] m_q[$];

  function automatic bit m_ready();
`ifdef WB_PIPE_REG_SKID_EN
    return m_q.size() < 2;
`else
    return out_ready || (m_q.size() == 0);
`endif
  endfunction

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
    end else begin
      bit acc, drn;
      acc = in_valid && m_ready();
      drn = (m_q.size() > 0) && out_ready;
      if (flush) begin
        m_q.delete();
      end else begin
        if (drn) void'(m_q.pop_front());
        if (acc) m_q.push_back(in_data);
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_n) begin
      check("model_valid", 64'(out_valid), 64'(m_q.size() > 0));
      check("model_count", 64'(count), 64'(m_q.size()));
      check("model_in_ready", 64'(in_ready), 64'(m_ready()));
      if (m_q.size() > 0) check("model_data", 64'(out_data), 64'(m_q[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] atom_entry(input int i);
    logic [7:0] k;
    k = 8'(i);
    return {8'h44 + k, 8'h33 + k, 8'h22 + k, 8'h11 + k};
  endfunction

  logic [31:0] exp_q[$];
  logic [31:0] got_word;

  initial begin
    int sent, got;
    flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
    in_valid4 = 0; out_ready4 = 0; in_data4 = '0;

    // Reset state.
    #2;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_data", 64'(out_data), 64'd0);
    @(posedge clk_i); @(posedge clk_i); #2;
    rst_n = 1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("post_rst_in_ready_edge", 64'(in_ready), 64'd1);

    // Streaming: 8 back-to-back entries, each out one cycle after input.
    out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1;
      in_data  = {32'(k + 100), 32'(k)};
      tick();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_lane0", 64'(out_data[0]), 64'(k));
      check("stream_lane1", 64'(out_data[1]), 64'(k + 100));
    end
    in_valid = 0;
    tick();
    check("stream_drained", 64'(out_valid), 64'd0);

    // Backpressure.
    out_ready = 0;
    in_valid  = 1;
    in_data   = {32'h0, 32'hA};
    tick();
    in_data = {32'h0, 32'hB};
`ifdef WB_PIPE_REG_SKID_EN
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check("bp_count", 64'(count), 64'd2);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_a", 64'(out_data[0]), 64'hA);
      tick();
    end
    out_ready = 1;
    tick();
    check("bp_then_b", 64'(out_data[0]), 64'hB);
    check("bp_count_b", 64'(count), 64'd1);
`else
    #1;
    check("bp_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_count", 64'(count), 64'd1);
      check("bp_hold_a", 64'(out_data[0]), 64'hA);
    end
    out_ready = 1;
    #1;
    check("bp_in_ready_up", 64'(in_ready), 64'd1);
    tick();
    check("bp_then_b", 64'(out_data[0]), 64'hB);
    in_valid = 0;
`endif
    tick();
    check("bp_empty", 64'(count), 64'd0);

    // Flush at full occupancy with a simultaneous input entry 0xC.
    out_ready = 0;
    in_valid  = 1;
    for (int i = 0; i < CAP; i++) begin
      in_data = {32'h0, 32'(32'hD0 + i)};
      tick();
    end
    check("flush_pre_count", 64'(count), 64'(CAP));
    flush = 1;
    in_data = {32'h0, 32'hC};
    out_ready = 1;
    tick();
    flush = 0;
    in_valid = 0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_data", 64'(out_data), 64'd0);
    tick();
    tick();
    check("flush_no_c", 64'(out_valid), 64'd0);

    // Random traffic checked against the model every cycle.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {32'($urandom), 32'($urandom)};
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      tick();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    tick(); tick(); tick();

    // Reset in the middle of a held transfer.
    out_ready = 0;
    in_valid  = 1;
    in_data   = {32'h12345678, 32'hDEADBEEF};
    tick();
    in_valid = 0;
    check("mid_rst_pre", 64'(out_data[0]), 64'hDEADBEEF);
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk_i); #2;
    rst_n = 1;
    #1;
    check("mid_rst_release_ready", 64'(in_ready), 64'd1);
    tick();
    check("mid_rst_first_ready", 64'(in_ready), 64'd1);
    check("mid_rst_first_valid", 64'(out_valid), 64'd0);

    // Lane atomicity on the 4-lane instance under random out_ready.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      in_valid4  = (sent < 16);
      in_data4   = atom_entry(sent);
      out_ready4 = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      if (out_valid4 && out_ready4) begin
        if (exp_q.size() == 0) begin
          check("atom_spurious", 64'(out_data4), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          got_word = exp_q.pop_front();
          if (got == 0) check("atom_first", 64'(out_data4), 64'h44332211);
          check("atom_entry", 64'(out_data4), 64'(got_word));
        end
        got++;
      end
      if (in_valid4 && in_ready4) begin
        exp_q.push_back(atom_entry(sent));
        sent++;
      end
      tick();
    end
    in_valid4 = 0;
    check("atom_delivered", 64'(got), 64'd16);
    check("atom_leftover", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
